// File: rtl/alu_mdu_if.sv
// ---------------------------------------------------------------------------
// alu_mdu_if
// Bundles the decode-stage handshake between the main controller, the
// register-file read ports and the ALU/MDU controller.
//
// Signals (named from the controller's point of view):
//   i_issue     instruction in decode is valid this cycle
//   i_alu_ctrl  main controller class: 00 MTYPE, 01 BTYPE, 10 RTYPE, 11 JTYPE
//   i_func      R-type function field
//   i_rs_val    first operand (multiplicand / dividend)
//   i_rt_val    second operand (multiplier / divisor)
//   o_alu_op    single-cycle ALU operation
//   o_stall     upstream must hold the instruction
//   o_mdu_done  one-cycle pulse, HI/LO were just updated
//   o_hi/o_lo   HI and LO registers
//   o_mf_data   HI or LO for MFHI/MFLO, zero otherwise
//
// Modports: master drives the i_* side (decode stage / testbench),
//           slave is the controller itself.
// ---------------------------------------------------------------------------
interface alu_mdu_if #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 6,
    parameter int OP_W   = 3
);
    logic              i_issue;
    logic [1:0]        i_alu_ctrl;
    logic [FUNC_W-1:0] i_func;
    logic [WIDTH-1:0]  i_rs_val;
    logic [WIDTH-1:0]  i_rt_val;

    logic [OP_W-1:0]   o_alu_op;
    logic              o_stall;
    logic              o_mdu_done;
    logic [WIDTH-1:0]  o_hi;
    logic [WIDTH-1:0]  o_lo;
    logic [WIDTH-1:0]  o_mf_data;

    modport master (
        output i_issue, i_alu_ctrl, i_func, i_rs_val, i_rt_val,
        input  o_alu_op, o_stall, o_mdu_done, o_hi, o_lo, o_mf_data
    );

    modport slave (
        input  i_issue, i_alu_ctrl, i_func, i_rs_val, i_rt_val,
        output o_alu_op, o_stall, o_mdu_done, o_hi, o_lo, o_mf_data
    );
endinterface

// File: rtl/alu_mdu_controller.sv
// ---------------------------------------------------------------------------
// alu_mdu_controller
// ALU controller for the MIPS-subset datapath. Decodes alu_ctrl/func into a
// combinational alu_op for single-cycle instructions and runs a sequential
// unsigned multiply/divide unit (MULTU/DIVU) that owns the HI/LO registers,
// serves MFHI/MFLO and stalls the pipeline while it iterates.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   alu_mdu_if.slave carrying issue/alu_ctrl/func/rs_val/rt_val in and
//         alu_op/stall/mdu_done/hi/lo/mf_data out
//
// WIDTH must be at least 4.
// ---------------------------------------------------------------------------
module alu_mdu_controller #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 6,
    parameter int OP_W   = 3
) (
    input  logic         clk,
    input  logic         rst,
    alu_mdu_if.slave     bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    localparam logic [1:0] CTRL_MTYPE = 2'b00;
    localparam logic [1:0] CTRL_BTYPE = 2'b01;
    localparam logic [1:0] CTRL_RTYPE = 2'b10;
    localparam logic [1:0] CTRL_JTYPE = 2'b11;

    localparam logic [FUNC_W-1:0] F_ADD   = FUNC_W'(6'b100000);
    localparam logic [FUNC_W-1:0] F_SUB   = FUNC_W'(6'b100010);
    localparam logic [FUNC_W-1:0] F_AND   = FUNC_W'(6'b100100);
    localparam logic [FUNC_W-1:0] F_OR    = FUNC_W'(6'b100101);
    localparam logic [FUNC_W-1:0] F_SLT   = FUNC_W'(6'b101010);
    localparam logic [FUNC_W-1:0] F_MULTU = FUNC_W'(6'b011001);
    localparam logic [FUNC_W-1:0] F_DIVU  = FUNC_W'(6'b011011);
    localparam logic [FUNC_W-1:0] F_MFHI  = FUNC_W'(6'b010000);
    localparam logic [FUNC_W-1:0] F_MFLO  = FUNC_W'(6'b010010);

    localparam logic [OP_W-1:0] OP_AND = OP_W'(3'b000);
    localparam logic [OP_W-1:0] OP_OR  = OP_W'(3'b001);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(3'b010);
    localparam logic [OP_W-1:0] OP_OFF = OP_W'(3'b011);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(3'b110);
    localparam logic [OP_W-1:0] OP_SLT = OP_W'(3'b111);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_operand;
    logic [WIDTH-1:0] r_accHi;
    logic [WIDTH-1:0] r_accLo;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_mduDone;

    logic [OP_W-1:0]  w_aluOp;
    logic             w_isRtype;
    logic             w_isIdle;
    logic             w_isMultu;
    logic             w_isDivu;
    logic             w_start;
    logic             w_divByZero;
    logic [WIDTH-1:0] w_mfData;
    logic [WIDTH-1:0] w_addend;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;
    logic             w_qBit;
    logic [WIDTH-1:0] w_remNext;

    // Single-cycle decode. It looks only at alu_ctrl/func, so the main
    // datapath sees the same alu_op whether or not the MDU is busy; every
    // MDU-related or unknown func maps to OFF so the ALU result is unused.
    always_comb begin
        w_aluOp = OP_OFF;
        case (bus.i_alu_ctrl)
            CTRL_MTYPE: w_aluOp = OP_ADD;
            CTRL_BTYPE: w_aluOp = OP_SUB;
            CTRL_JTYPE: w_aluOp = OP_OFF;
            CTRL_RTYPE: begin
                case (bus.i_func)
                    F_ADD:   w_aluOp = OP_ADD;
                    F_SUB:   w_aluOp = OP_SUB;
                    F_AND:   w_aluOp = OP_AND;
                    F_OR:    w_aluOp = OP_OR;
                    F_SLT:   w_aluOp = OP_SLT;
                    default: w_aluOp = OP_OFF;
                endcase
            end
            default: w_aluOp = OP_OFF;
        endcase
    end

    // Issue qualification. A new MDU op is only accepted while idle; while
    // busy the upstream instruction is held by stall and simply ignored here.
    // Stall covers the accepting cycle too so the decode stage does not
    // advance past a MULTU/DIVU that has just been captured.
    always_comb begin
        w_isRtype   = (bus.i_alu_ctrl == CTRL_RTYPE);
        w_isIdle    = (r_state == S_IDLE);
        w_isMultu   = (bus.i_func == F_MULTU);
        w_isDivu    = (bus.i_func == F_DIVU);
        w_start     = bus.i_issue & w_isRtype & (w_isMultu | w_isDivu) & w_isIdle;
        w_divByZero = w_isDivu & (bus.i_rt_val == '0);
    end

    // MFHI/MFLO readout comes straight off the HI/LO registers, so a move
    // issued in the mdu_done cycle already sees the freshly written result.
    always_comb begin
        w_mfData = '0;
        if (bus.i_issue && w_isRtype && w_isIdle) begin
            if (bus.i_func == F_MFHI) begin
                w_mfData = r_hi;
            end else if (bus.i_func == F_MFLO) begin
                w_mfData = r_lo;
            end
        end
    end

    // One iteration of each algorithm. accHi:accLo is a shared 2W-bit
    // working register: for multiply it holds partial-product:multiplier and
    // shifts right; for divide it holds remainder:dividend/quotient and
    // shifts left. The subtraction only needs W bits because it is used
    // solely when the shifted remainder is at least the divisor, so the true
    // difference is below the divisor and fits.
    always_comb begin
        w_addend  = r_accLo[0] ? r_operand : '0;
        w_sum     = {1'b0, r_accHi} + {1'b0, w_addend};
        w_shift   = {r_accHi, r_accLo[WIDTH-1]};
        w_qBit    = (w_shift >= {1'b0, r_operand});
        w_diff    = w_shift[WIDTH-1:0] - r_operand;
        w_remNext = w_qBit ? w_diff : w_shift[WIDTH-1:0];
    end

    // MDU state machine. Operands are captured on start; each busy cycle
    // performs one iteration, and the edge that completes iteration WIDTH-1
    // writes HI/LO, returns to idle and raises mdu_done for one cycle.
    // Divide-by-zero never leaves idle: HI takes the dividend and LO all
    // ones at the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_operand <= '0;
            r_accHi   <= '0;
            r_accLo   <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mduDone <= 1'b0;
        end else begin
            r_mduDone <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_count   <= '0;
                        r_accHi   <= '0;
                        r_operand <= w_isMultu ? bus.i_rs_val : bus.i_rt_val;
                        r_accLo   <= w_isMultu ? bus.i_rt_val : bus.i_rs_val;
                        if (w_divByZero) begin
                            r_hi      <= bus.i_rs_val;
                            r_lo      <= '1;
                            r_mduDone <= 1'b1;
                        end else begin
                            r_state <= w_isMultu ? S_MUL : S_DIV;
                        end
                    end
                end
                S_MUL: begin
                    r_accHi <= w_sum[WIDTH:1];
                    r_accLo <= {w_sum[0], r_accLo[WIDTH-1:1]};
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == LAST_ITER) begin
                        r_hi      <= w_sum[WIDTH:1];
                        r_lo      <= {w_sum[0], r_accLo[WIDTH-1:1]};
                        r_state   <= S_IDLE;
                        r_mduDone <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_accHi <= w_remNext;
                    r_accLo <= {r_accLo[WIDTH-2:0], w_qBit};
                    r_count <= r_count + CNT_W'(1);
                    if (r_count == LAST_ITER) begin
                        r_hi      <= w_remNext;
                        r_lo      <= {r_accLo[WIDTH-2:0], w_qBit};
                        r_state   <= S_IDLE;
                        r_mduDone <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.o_alu_op   = w_aluOp;
    assign bus.o_stall    = w_start | ~w_isIdle;
    assign bus.o_mdu_done = r_mduDone;
    assign bus.o_hi       = r_hi;
    assign bus.o_lo       = r_lo;
    assign bus.o_mf_data  = w_mfData;

endmodule

// File: tb/tb_alu_mdu_controller.sv
// ---------------------------------------------------------------------------
// tb_alu_mdu_controller
// Directed bench for alu_mdu_controller at WIDTH=32. Inputs change 1ns after
// the rising edge; outputs are sampled on the falling edge of the same cycle.
// ---------------------------------------------------------------------------
module tb_alu_mdu_controller;

    localparam int WIDTH  = 32;
    localparam int FUNC_W = 6;
    localparam int OP_W   = 3;

    localparam logic [1:0] MTYPE = 2'b00;
    localparam logic [1:0] BTYPE = 2'b01;
    localparam logic [1:0] RTYPE = 2'b10;
    localparam logic [1:0] JTYPE = 2'b11;

    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    logic clk = 1'b0;
    logic rst;
    int   assertCount = 0;
    int   failCount   = 0;

    alu_mdu_if #(.WIDTH(WIDTH), .FUNC_W(FUNC_W), .OP_W(OP_W)) bus ();

    alu_mdu_controller #(.WIDTH(WIDTH), .FUNC_W(FUNC_W), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // 10ns clock
    always #5 clk = ~clk;

    // Hard time limit so a wedged DUT can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one cycle worth of decode-stage inputs just after the edge
    task automatic applyStimulus(input logic iss, input logic [1:0] ctrl, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        bus.i_issue    = iss;
        bus.i_alu_ctrl = ctrl;
        bus.i_func     = fn;
        bus.i_rs_val   = a;
        bus.i_rt_val   = b;
    endtask

    // Steps cycles after an accepted MDU issue until stall drops (bounded).
    // Returns the total stall cycles including the issue cycle, and the number
    // of busy cycles whose outputs broke the busy-time expectations. Ends at
    // the falling edge of the first non-stalled cycle.
    task automatic runUntilIdle(input logic holdIss, input logic [5:0] holdFunc,
                                input logic [31:0] holdHi, input logic [31:0] holdLo,
                                output int stallCycles, output int busyBad);
        stallCycles = 1;
        busyBad     = 0;
        for (int k = 0; k < 40; k++) begin
            applyStimulus(holdIss, RTYPE, holdFunc, 32'h0, 32'h0);
            @(negedge clk);
            if (!bus.o_stall) break;
            stallCycles++;
            if (bus.o_mdu_done !== 1'b0 || bus.o_mf_data !== 32'h0 ||
                bus.o_hi !== holdHi || bus.o_lo !== holdLo) busyBad++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.i_issue    = 1'b0;
        bus.i_alu_ctrl = RTYPE;
        bus.i_func     = 6'h0;
        bus.i_rs_val   = 32'h0;
        bus.i_rt_val   = 32'h0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        assertCount++;
        if (bus.o_stall !== 1'b0) begin
            failCount++; $display("[TB] FAIL reset_stall: got %0b expected 0", bus.o_stall);
        end
        assertCount++;
        if (bus.o_mdu_done !== 1'b0) begin
            failCount++; $display("[TB] FAIL reset_done: got %0b expected 0", bus.o_mdu_done);
        end
        assertCount++;
        if (bus.o_hi !== 32'h0 || bus.o_lo !== 32'h0) begin
            failCount++; $display("[TB] FAIL reset_hilo: got hi=%h lo=%h expected 0/0", bus.o_hi, bus.o_lo);
        end
    endtask

    task automatic test_decode();
        logic [1:0] ctrlTab [11] = '{RTYPE, RTYPE, RTYPE, RTYPE, RTYPE, MTYPE, BTYPE, JTYPE,
                                     RTYPE, RTYPE, RTYPE};
        logic [5:0] funcTab [11] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                     6'b100010, 6'b100100, 6'b100000, 6'b111111, F_MULTU, F_MFHI};
        logic [2:0] expTab  [11] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b010, 3'b110,
                                     3'b011, 3'b011, 3'b011, 3'b011};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(1'b0, ctrlTab[i], funcTab[i], 32'h5, 32'h3);
            @(negedge clk);
            assertCount++;
            if (bus.o_alu_op !== expTab[i]) begin
                failCount++;
                $display("[TB] FAIL decode_%0d: got alu_op=%b expected %b", i, bus.o_alu_op, expTab[i]);
            end
            assertCount++;
            if (bus.o_stall !== 1'b0 || bus.o_mdu_done !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL decode_quiet_%0d: got stall=%b done=%b expected 0/0",
                         i, bus.o_stall, bus.o_mdu_done);
            end
        end
    endtask

    task automatic test_multu();
        int n, bad;
        applyStimulus(1'b1, RTYPE, F_MULTU, 32'hFFFF_FFFF, 32'h2);
        @(negedge clk);
        assertCount++;
        if (bus.o_stall !== 1'b1) begin
            failCount++; $display("[TB] FAIL multu_issue_stall: got %0b expected 1", bus.o_stall);
        end
        runUntilIdle(1'b0, 6'h0, 32'h0, 32'h0, n, bad);
        assertCount++;
        if (n != 33) begin
            failCount++; $display("[TB] FAIL multu_stall_cycles: got %0d expected 33", n);
        end
        assertCount++;
        if (bad != 0) begin
            failCount++; $display("[TB] FAIL multu_busy_outputs: got %0d bad cycles expected 0", bad);
        end
        assertCount++;
        if (bus.o_mdu_done !== 1'b1 || bus.o_hi !== 32'h1 || bus.o_lo !== 32'hFFFF_FFFE) begin
            failCount++;
            $display("[TB] FAIL multu_result: got done=%b hi=%h lo=%h expected 1/00000001/fffffffe",
                     bus.o_mdu_done, bus.o_hi, bus.o_lo);
        end
        applyStimulus(1'b0, RTYPE, 6'h0, 32'h0, 32'h0);
        @(negedge clk);
        assertCount++;
        if (bus.o_mdu_done !== 1'b0) begin
            failCount++; $display("[TB] FAIL multu_done_pulse: got %0b expected 0", bus.o_mdu_done);
        end
    endtask

    task automatic test_divu();
        int n, bad;
        applyStimulus(1'b1, RTYPE, F_DIVU, 32'd100, 32'd7);
        runUntilIdle(1'b0, 6'h0, 32'h1, 32'hFFFF_FFFE, n, bad);
        assertCount++;
        if (n != 33 || bad != 0) begin
            failCount++; $display("[TB] FAIL divu_busy: got stall=%0d bad=%0d expected 33/0", n, bad);
        end
        assertCount++;
        if (bus.o_mdu_done !== 1'b1 || bus.o_lo !== 32'd14 || bus.o_hi !== 32'd2) begin
            failCount++;
            $display("[TB] FAIL divu_result: got done=%b lo=%0d hi=%0d expected 1/14/2",
                     bus.o_mdu_done, bus.o_lo, bus.o_hi);
        end
        applyStimulus(1'b1, RTYPE, F_MFLO, 32'h0, 32'h0);
        @(negedge clk);
        assertCount++;
        if (bus.o_mf_data !== 32'd14 || bus.o_alu_op !== 3'b011 || bus.o_stall !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL divu_mflo: got mf=%0d op=%b stall=%b expected 14/011/0",
                     bus.o_mf_data, bus.o_alu_op, bus.o_stall);
        end
        applyStimulus(1'b1, RTYPE, F_MFHI, 32'h0, 32'h0);
        @(negedge clk);
        assertCount++;
        if (bus.o_mf_data !== 32'd2) begin
            failCount++; $display("[TB] FAIL divu_mfhi: got %0d expected 2", bus.o_mf_data);
        end
        applyStimulus(1'b1, RTYPE, F_DIVU, 32'hFFFF_FFFF, 32'h10);
        runUntilIdle(1'b0, 6'h0, 32'd2, 32'd14, n, bad);
        assertCount++;
        if (n != 33 || bus.o_lo !== 32'h0FFF_FFFF || bus.o_hi !== 32'hF) begin
            failCount++;
            $display("[TB] FAIL divu_big: got stall=%0d lo=%h hi=%h expected 33/0fffffff/0000000f",
                     n, bus.o_lo, bus.o_hi);
        end
    endtask

    task automatic test_div_zero();
        applyStimulus(1'b1, RTYPE, F_DIVU, 32'd5, 32'd0);
        @(negedge clk);
        assertCount++;
        if (bus.o_stall !== 1'b1 || bus.o_mdu_done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL divzero_issue: got stall=%b done=%b expected 1/0", bus.o_stall, bus.o_mdu_done);
        end
        applyStimulus(1'b0, RTYPE, 6'h0, 32'h0, 32'h0);
        @(negedge clk);
        assertCount++;
        if (bus.o_stall !== 1'b0 || bus.o_mdu_done !== 1'b1 ||
            bus.o_hi !== 32'd5 || bus.o_lo !== 32'hFFFF_FFFF) begin
            failCount++;
            $display("[TB] FAIL divzero_result: got stall=%b done=%b hi=%h lo=%h expected 0/1/00000005/ffffffff",
                     bus.o_stall, bus.o_mdu_done, bus.o_hi, bus.o_lo);
        end
        applyStimulus(1'b0, RTYPE, 6'h0, 32'h0, 32'h0);
        @(negedge clk);
        assertCount++;
        if (bus.o_mdu_done !== 1'b0) begin
            failCount++; $display("[TB] FAIL divzero_done_pulse: got %0b expected 0", bus.o_mdu_done);
        end
    endtask

    task automatic test_mf_while_busy();
        int n, bad;
        applyStimulus(1'b1, RTYPE, F_MULTU, 32'h0001_0000, 32'h0001_0000);
        runUntilIdle(1'b1, F_MFHI, 32'd5, 32'hFFFF_FFFF, n, bad);
        assertCount++;
        if (n != 33 || bad != 0) begin
            failCount++; $display("[TB] FAIL mfbusy_hold: got stall=%0d bad=%0d expected 33/0", n, bad);
        end
        assertCount++;
        if (bus.o_mdu_done !== 1'b1 || bus.o_mf_data !== 32'h1 || bus.o_hi !== 32'h1 || bus.o_lo !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL mfbusy_done: got done=%b mf=%h hi=%h lo=%h expected 1/00000001/00000001/00000000",
                     bus.o_mdu_done, bus.o_mf_data, bus.o_hi, bus.o_lo);
        end
    endtask

    task automatic test_reset_mid_op();
        int n, bad, donePulses;
        applyStimulus(1'b1, RTYPE, F_MULTU, 32'd7, 32'd9);
        repeat (10) applyStimulus(1'b0, RTYPE, 6'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        assertCount++;
        if (bus.o_stall !== 1'b0 || bus.o_hi !== 32'h0 || bus.o_lo !== 32'h0 || bus.o_mdu_done !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL midreset_state: got stall=%b hi=%h lo=%h done=%b expected 0/0/0/0",
                     bus.o_stall, bus.o_hi, bus.o_lo, bus.o_mdu_done);
        end
        donePulses = 0;
        for (int k = 0; k < 30; k++) begin
            applyStimulus(1'b0, RTYPE, 6'h0, 32'h0, 32'h0);
            @(negedge clk);
            if (bus.o_mdu_done !== 1'b0 || bus.o_stall !== 1'b0) donePulses++;
        end
        assertCount++;
        if (donePulses != 0) begin
            failCount++; $display("[TB] FAIL midreset_quiet: got %0d active cycles expected 0", donePulses);
        end
        applyStimulus(1'b1, RTYPE, F_MULTU, 32'd3, 32'd4);
        runUntilIdle(1'b0, 6'h0, 32'h0, 32'h0, n, bad);
        assertCount++;
        if (n != 33 || bad != 0 || bus.o_mdu_done !== 1'b1 || bus.o_lo !== 32'd12 || bus.o_hi !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL midreset_rerun: got stall=%0d bad=%0d done=%b lo=%0d hi=%0d expected 33/0/1/12/0",
                     n, bad, bus.o_mdu_done, bus.o_lo, bus.o_hi);
        end
    endtask

    task automatic test_back_to_back();
        int n, bad;
        applyStimulus(1'b1, RTYPE, F_MULTU, 32'h1234_5678, 32'h10);
        repeat (32) applyStimulus(1'b0, RTYPE, 6'h0, 32'h0, 32'h0);
        applyStimulus(1'b1, RTYPE, F_MULTU, 32'd5, 32'd6);
        @(negedge clk);
        assertCount++;
        if (bus.o_mdu_done !== 1'b1 || bus.o_stall !== 1'b1 ||
            bus.o_hi !== 32'h1 || bus.o_lo !== 32'h2345_6780) begin
            failCount++;
            $display("[TB] FAIL b2b_first: got done=%b stall=%b hi=%h lo=%h expected 1/1/00000001/23456780",
                     bus.o_mdu_done, bus.o_stall, bus.o_hi, bus.o_lo);
        end
        runUntilIdle(1'b0, 6'h0, 32'h1, 32'h2345_6780, n, bad);
        assertCount++;
        if (n != 33 || bad != 0) begin
            failCount++; $display("[TB] FAIL b2b_busy: got stall=%0d bad=%0d expected 33/0", n, bad);
        end
        assertCount++;
        if (bus.o_mdu_done !== 1'b1 || bus.o_hi !== 32'h0 || bus.o_lo !== 32'd30) begin
            failCount++;
            $display("[TB] FAIL b2b_second: got done=%b hi=%h lo=%0d expected 1/00000000/30",
                     bus.o_mdu_done, bus.o_hi, bus.o_lo);
        end
    endtask

    initial begin
        $display("[TB] starting alu_mdu_controller bench");
        test_reset();
        test_decode();
        test_multu();
        test_divu();
        test_div_zero();
        test_mf_while_busy();
        applyStimulus(1'b0, RTYPE, 6'h0, 32'h0, 32'h0);
        test_reset_mid_op();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
